// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller for the IF-DOF-EX-WB pipeline: 2-entry write scoreboard, stall, bubble and branch squash.
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int FLUSH_EXTRA = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DOF_RW,
  input  logic [ADDR_W-1:0] DOF_DA,
  input  logic [ADDR_W-1:0] DOF_AA,
  input  logic [ADDR_W-1:0] DOF_BA,
  input  logic              DOF_MA,
  input  logic              DOF_MB,
  input  logic [1:0]        DOF_MD,
  input  logic [1:0]        DOF_BS,
  input  logic              EX_BR_TAKEN,
  output logic              PC_HOLD,
  output logic              IR_HOLD,
  output logic              EX_BUBBLE,
  output logic              IR_FLUSH,
  output logic [1:0]        FWD_A_SEL,
  output logic [1:0]        FWD_B_SEL
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_EXTRA);

  state_t            state_r;
  logic [1:0]        cnt_r;
  logic              ex_vld_r;
  logic [ADDR_W-1:0] ex_da_r;
  logic              ex_ld_r;
  logic              wb_vld_r;
  logic [ADDR_W-1:0] wb_da_r;

  logic              a_rd_s;
  logic              b_rd_s;
  logic [2:0]        a_chk_s;
  logic [2:0]        b_chk_s;
  logic              stall_s;
  logic              bubble_s;
  logic              flush_s;

  // Per-operand check; returns {stall, forward select}. R0 never matches.
  function automatic logic [2:0] src_check(
    input logic              rd,
    input logic [ADDR_W-1:0] src,
    input logic              e_vld,
    input logic [ADDR_W-1:0] e_da,
    input logic              e_ld,
    input logic              w_vld,
    input logic [ADDR_W-1:0] w_da
  );
    logic m_ex;
    logic m_wb;
    logic [2:0] res;
    m_ex = rd & e_vld & (e_da == src) & (src != {ADDR_W{1'b0}});
    m_wb = rd & w_vld & (w_da == src) & (src != {ADDR_W{1'b0}});
`ifdef HAZARD_FWD_EN
    if (m_ex && !e_ld) begin
      res = 3'b001;
    end else if (m_ex) begin
      res = 3'b100;
    end else if (m_wb) begin
      res = 3'b010;
    end else begin
      res = 3'b000;
    end
`else
    res = {(m_ex & ~e_ld) | (m_ex & e_ld) | m_wb, 2'b00};
`endif
    return res;
  endfunction

  // Operand usage and hazard evaluation against the registered scoreboard
  always_comb begin
    a_rd_s   = (DOF_MA == 1'b0) || (DOF_BS == 2'b10);
    b_rd_s   = (DOF_MB == 1'b0);
    a_chk_s  = src_check(a_rd_s, DOF_AA, ex_vld_r, ex_da_r, ex_ld_r, wb_vld_r, wb_da_r);
    b_chk_s  = src_check(b_rd_s, DOF_BA, ex_vld_r, ex_da_r, ex_ld_r, wb_vld_r, wb_da_r);
    stall_s  = a_chk_s[2] | b_chk_s[2];
    bubble_s = stall_s | EX_BR_TAKEN;
    flush_s  = EX_BR_TAKEN | (state_r == ST_FLUSH);
  end

  // Pipeline control outputs; a taken branch overrides a data stall
  always_comb begin
    PC_HOLD   = 1'b0;
    IR_HOLD   = 1'b0;
    EX_BUBBLE = 1'b0;
    IR_FLUSH  = 1'b0;
    FWD_A_SEL = 2'b00;
    FWD_B_SEL = 2'b00;
    if (RESET) begin
      PC_HOLD   = 1'b0;
      IR_HOLD   = 1'b0;
      EX_BUBBLE = 1'b0;
      IR_FLUSH  = 1'b0;
    end else begin
      PC_HOLD   = stall_s & ~EX_BR_TAKEN;
      IR_HOLD   = stall_s & ~EX_BR_TAKEN & ~flush_s;
      EX_BUBBLE = bubble_s;
      IR_FLUSH  = flush_s;
      FWD_A_SEL = a_chk_s[1:0];
      FWD_B_SEL = b_chk_s[1:0];
    end
  end

  // Scoreboard shift and RUN/FLUSH state machine
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= ST_RUN;
      cnt_r    <= 2'd0;
      ex_vld_r <= 1'b0;
      ex_da_r  <= {ADDR_W{1'b0}};
      ex_ld_r  <= 1'b0;
      wb_vld_r <= 1'b0;
      wb_da_r  <= {ADDR_W{1'b0}};
    end else begin
      wb_vld_r <= ex_vld_r;
      wb_da_r  <= ex_da_r;
      ex_vld_r <= bubble_s ? 1'b0 : (DOF_RW & (DOF_DA != {ADDR_W{1'b0}}));
      ex_da_r  <= DOF_DA;
      ex_ld_r  <= (DOF_MD == 2'b01);
      case (state_r)
        ST_RUN: begin
          if (EX_BR_TAKEN && (FLUSH_LOAD != 2'd0)) begin
            state_r <= ST_FLUSH;
            cnt_r   <= FLUSH_LOAD;
          end else begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
          end
        end
        ST_FLUSH: begin
          if (EX_BR_TAKEN) begin
            state_r <= ST_FLUSH;
            cnt_r   <= FLUSH_LOAD;
          end else if (cnt_r <= 2'd1) begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
          end else begin
            state_r <= ST_FLUSH;
            cnt_r   <= cnt_r - 2'd1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (FLUSH_EXTRA=1); forwarding vectors when HAZARD_FWD_EN is defined.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DOF_RW;
  logic [4:0] DOF_DA, DOF_AA, DOF_BA;
  logic       DOF_MA, DOF_MB;
  logic [1:0] DOF_MD, DOF_BS;
  logic       EX_BR_TAKEN;
  logic       PC_HOLD, IR_HOLD, EX_BUBBLE, IR_FLUSH;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;

  int errors = 0;
  int checks = 0;

  // expected = {PC_HOLD, IR_HOLD, EX_BUBBLE, IR_FLUSH, FWD_A_SEL, FWD_B_SEL}
  localparam logic [7:0] Z   = 8'b0000_0000;
  localparam logic [7:0] S   = 8'b1110_0000;
  localparam logic [7:0] BRF = 8'b0011_0000;
  localparam logic [7:0] FL  = 8'b0001_0000;

  typedef struct {
    logic       rst, rw;
    logic [4:0] da, aa, ba;
    logic       ma, mb;
    logic [1:0] md, bs;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  pipeline_hazard_ctrl #(.ADDR_W(5), .FLUSH_EXTRA(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .DOF_RW(DOF_RW), .DOF_DA(DOF_DA), .DOF_AA(DOF_AA), .DOF_BA(DOF_BA),
    .DOF_MA(DOF_MA), .DOF_MB(DOF_MB), .DOF_MD(DOF_MD), .DOF_BS(DOF_BS),
    .EX_BR_TAKEN(EX_BR_TAKEN),
    .PC_HOLD(PC_HOLD), .IR_HOLD(IR_HOLD), .EX_BUBBLE(EX_BUBBLE), .IR_FLUSH(IR_FLUSH),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic v(input logic rst, input logic rw, input logic [4:0] da, input logic [4:0] aa,
                   input logic [4:0] ba, input logic ma, input logic mb, input logic [1:0] md,
                   input logic [1:0] bs, input logic br, input logic [7:0] exp);
    vec_t t;
    t.rst = rst; t.rw = rw; t.da = da; t.aa = aa; t.ba = ba;
    t.ma = ma; t.mb = mb; t.md = md; t.bs = bs; t.br = br; t.exp = exp;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs at the falling edge and compare mid-cycle
  task automatic apply(input vec_t t, input string name);
    logic [7:0] got;
    @(negedge CLK);
    RESET = t.rst; DOF_RW = t.rw; DOF_DA = t.da; DOF_AA = t.aa; DOF_BA = t.ba;
    DOF_MA = t.ma; DOF_MB = t.mb; DOF_MD = t.md; DOF_BS = t.bs; EX_BR_TAKEN = t.br;
    #2;
    got = {PC_HOLD, IR_HOLD, EX_BUBBLE, IR_FLUSH, FWD_A_SEL, FWD_B_SEL};
    checks++;
    if (got !== t.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, t.exp);
    end
  endtask

  task automatic nop_step(input logic rst, input logic br, input logic [7:0] exp, input string name);
    vec_t t;
    t.rst = rst; t.rw = 1'b0; t.da = 5'd0; t.aa = 5'd0; t.ba = 5'd0;
    t.ma = 1'b0; t.mb = 1'b0; t.md = 2'b00; t.bs = 2'b00; t.br = br; t.exp = exp;
    apply(t, name);
  endtask

  initial begin
    // reset and NOP stream
    v(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
`ifndef HAZARD_FWD_EN
    // ADD R3,R1,R2 ; ADD R4,R3,R1 -> 2-cycle stall
    v(1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    // R0 destination/source never hazards
    v(1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    // write R7, then NOT R5,R6 with BA=7 unread -> no stall
    v(1'b0, 1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, Z);
    // write R6, then NOT R5,R6 -> A match stalls
    v(1'b0, 1'b1, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, Z);
    // dependent stall coincides with taken branch, then one flush cycle
    v(1'b0, 1'b1, 5'd2, 5'd1, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd3, 5'd2, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, BRF);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, FL);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    // reset during second stall cycle clears the scoreboard
    v(1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, S);
    v(1'b1, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    // distance-2 dependency -> 1-cycle stall
    v(1'b0, 1'b1, 5'd1, 5'd2, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    // JMR reads A via BS even though MA=1
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, S);
    v(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, Z);
`else
    // ADD R3 ; SUB R5,R3,R3 -> EX forward on both operands
    v(1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd5, 5'd3, 5'd3, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_0101);
    v(1'b0, 1'b1, 5'd6, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_1000);
    // LOD R3 ; ADD R6,R3,R1 -> 1-cycle stall then WB forward
    v(1'b0, 1'b1, 5'd3, 5'd1, 5'd0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd6, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, S);
    v(1'b0, 1'b1, 5'd6, 5'd3, 5'd1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_1000);
    v(1'b0, 1'b1, 5'd7, 5'd6, 5'd6, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'b0000_0101);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
    v(1'b0, 1'b1, 5'd2, 5'd1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, BRF);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, FL);
    v(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, Z);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // branch while already flushing reloads the counter
    nop_step(1'b0, 1'b1, BRF, "br_run");
    nop_step(1'b0, 1'b1, BRF, "br_in_flush");
    nop_step(1'b0, 1'b0, FL,  "flush_tail");
    nop_step(1'b0, 1'b0, Z,   "back_to_run");
    // reset mid-flush returns to RUN
    nop_step(1'b0, 1'b1, BRF, "br_before_rst");
    nop_step(1'b1, 1'b0, Z,   "rst_in_flush");
    nop_step(1'b0, 1'b0, Z,   "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and flush controller for the 4-stage RISC pipeline (IF, DOF, EX, WB). It takes the control word produced by Instruction_decoder for the instruction in DOF and keeps a 2-entry register-write scoreboard covering the EX and WB stages. From these it generates PC/IR hold, EX-stage bubble insertion and IR squash on taken branches. It sits between the decoder outputs and the DOF/EX pipeline register enables.

Parameters:
ADDR_W, 5, register address width (DA/AA/BA).
FLUSH_EXTRA, 0, number of extra cycles IR_FLUSH stays high after a taken branch (0..3); covers instruction-memory latency.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RESET  in  1  synchronous, active-high reset.
DOF_RW  in  1  decoder RW for the DOF instruction.
DOF_DA  in  ADDR_W  decoder DA.
DOF_AA  in  ADDR_W  decoder AA.
DOF_BA  in  ADDR_W  decoder BA.
DOF_MA  in  1  decoder MA.
DOF_MB  in  1  decoder MB.
DOF_MD  in  2  decoder MD; 2'b01 marks a load.
DOF_BS  in  2  decoder BS.
EX_BR_TAKEN  in  1  branch/jump in EX resolved taken this cycle.
PC_HOLD  out  1  PC keeps its value.
IR_HOLD  out  1  IR keeps its value.
EX_BUBBLE  out  1  EX pipeline register loads a NOP (RW=0, MW=0, BS=00).
IR_FLUSH  out  1  IR loads a NOP instead of the fetched word.
FWD_A_SEL  out  2  A operand source: 00 regfile, 01 EX result, 10 WB result. Present only with the optional feature; otherwise tied to 00.
FWD_B_SEL  out  2  Same encoding for the B operand.

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high.
- Reset: every output is 0, both scoreboard entries are invalid, the FSM is in RUN and the flush counter is 0. RESET overrides all other inputs in the same edge.
- Scoreboard, per entry: vld, da, ld.
  - Each edge, EX shifts to WB.
  - EX loads {DOF_RW & (DOF_DA!=0), DOF_DA, DOF_MD==2'b01}.
  - When EX_BUBBLE=1, EX loads vld=0 instead.
- R0 is hardwired zero: a destination of 0 is never tracked, and a source of 0 never matches.
- Source usage:
  - A is read when DOF_MA==1'b0 or DOF_BS==2'b10 (JMR).
  - B is read when DOF_MB==1'b0.
  - An X or 1 on MA/MB means the operand is not read.
- Match rule: matchX_S = src read & entry X vld & (entry X da == src addr).
- Data hazard (base build): stall = any match against EX or WB.
- Stall response, combinational in the same cycle from registered scoreboard plus DOF inputs: PC_HOLD=1, IR_HOLD=1, EX_BUBBLE=1.
- Stall length: 2 cycles for a back-to-back dependency, 1 cycle for distance 2, 0 for distance 3 or more.
- FSM states: RUN and FLUSH.
  - RUN with EX_BR_TAKEN=1: EX_BUBBLE=1 and IR_FLUSH=1 this cycle; PC_HOLD=IR_HOLD=0. The branch overrides any data stall.
  - If FLUSH_EXTRA>0, go to FLUSH with cnt=FLUSH_EXTRA.
  - FLUSH: IR_FLUSH=1 and cnt decrements each cycle; return to RUN when cnt reaches 1. Hazard detection stays active on DOF, which holds a NOP.
  - EX_BR_TAKEN in FLUSH: reload cnt=FLUSH_EXTRA and assert EX_BUBBLE.
- IR_FLUSH and IR_HOLD never assert together; IR_FLUSH wins.
- Reset mid-stall or mid-flush: outputs go to 0 on the next edge and the scoreboard is cleared.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- When defined:
  - A match against EX with ld=0 sets SEL=01 and does not stall.
  - A match against WB sets SEL=10 and does not stall. Both loads and ALU results are forwarded from WB.
  - EX has priority over WB when both match.
  - A match against EX with ld=1 is a load-use hazard: 1-cycle stall, after which WB forwarding (10) applies.
- When undefined:
  - FWD_A_SEL/FWD_B_SEL are constant 00.
  - The base full-stall rule applies.

Test Plan:
1. Hold RESET=1 for 2 cycles, then release with DOF inputs all 0 → all outputs 0 and no stall on a NOP stream.
2. Base build: ADD R3,R1,R2, then ADD R4,R3,R1 → PC_HOLD/IR_HOLD/EX_BUBBLE high for exactly 2 cycles; the dependent instruction enters EX on the 3rd cycle.
3. ADD R0,R1,R2, then ADD R4,R0,R0; and separately NOT R5,R6 (MB=x) following a write to R6's BA slot → no stall from R0 or from the unread B operand, but the A match on R6 stalls.
4. FLUSH_EXTRA=1: dependent stall active in DOF while EX_BR_TAKEN=1 → that cycle EX_BUBBLE=1, IR_FLUSH=1, PC_HOLD=0; the next cycle IR_FLUSH=1; then back in RUN with no residual stall.
5. HAZARD_FWD_EN: ADD R3, then SUB R5,R3,R3 → FWD_A_SEL=FWD_B_SEL=01, no stall. LOD R3, then ADD R6,R3,R1 → 1-cycle stall, then FWD_A_SEL=10.
6. Assert RESET during the second stall cycle → the next cycle has all outputs 0, and the dependent instruction proceeds with no stall.
